// File: rtl/widths_pkg.sv
// Shared definitions for the widths unpack path: FSM state encoding,
// output field select codes and the field-width helper.
package widths_pkg;

  // Unpacker sequencing: waiting for a word, presenting A, presenting B.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } unpack_state_t;

  // Values driven on out_sel to identify which field is on out_field.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Larger of two widths; used at elaboration time to size the output field.
  function automatic int wmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/widths_field_ext.sv
// Combinational width extender: widens one field to OUT_W bits.
// Zero-extends by default; with WIDTHS_UNPACK_SIGN_EXT_EN defined the
// field MSB is replicated instead. Equal widths pass straight through.
module widths_field_ext #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 1
) (
  input  logic [IN_W-1:0]  field,
  output logic [OUT_W-1:0] ext
);

  // Pick the extension form at elaboration time; OUT_W is never below IN_W.
  generate
    if (OUT_W == IN_W) begin : g_pass
      assign ext = field;
    end else begin : g_ext
`ifdef WIDTHS_UNPACK_SIGN_EXT_EN
      assign ext = {{(OUT_W-IN_W){field[IN_W-1]}}, field};
`else
      assign ext = {{(OUT_W-IN_W){1'b0}}, field};
`endif
    end
  endgenerate

endmodule

// File: rtl/widths_unpack.sv
// Serializing unpacker: takes one packed word {a, b} per input handshake
// and emits field A then field B on a single FW-wide output stream.
// Outputs are registered; in_ready in EMIT_B is the only combinational
// path (it follows out_ready so a new word can load with no bubble).
// Optional build macro: WIDTHS_UNPACK_SIGN_EXT_EN (sign-extend the narrower
// field instead of zero-extending it; handshake and timing are unchanged).
module widths_unpack
  import widths_pkg::*;
#(
  parameter  int WIDTH_A = 5,
  parameter  int WIDTH_B = 3,
  localparam int FW      = wmax(WIDTH_A, WIDTH_B)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_A+WIDTH_B-1:0] in_cat,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FW-1:0]              out_field,
  output logic                       out_sel,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  unpack_state_t        state, state_n;
  // Only B needs holding: A goes straight from in_cat into out_field.
  logic [WIDTH_B-1:0]   hold, hold_n;
  logic [FW-1:0]        field_n;
  logic                 sel_n, last_n, valid_n;
  logic [FW-1:0]        a_ext, b_ext;

  // A is widened from the incoming word, B from the hold register.
  widths_field_ext #(.IN_W(WIDTH_A), .OUT_W(FW)) u_ext_a (
    .field (in_cat[WIDTH_A+WIDTH_B-1:WIDTH_B]),
    .ext   (a_ext)
  );

  widths_field_ext #(.IN_W(WIDTH_B), .OUT_W(FW)) u_ext_b (
    .field (hold),
    .ext   (b_ext)
  );

  // Next-state, next-output and in_ready decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_n  = state;
    hold_n   = hold;
    field_n  = out_field;
    sel_n    = out_sel;
    last_n   = out_last;
    valid_n  = out_valid;
    in_ready = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_n  = in_cat[WIDTH_B-1:0];
          field_n = a_ext;
          sel_n   = SEL_A;
          last_n  = 1'b0;
          valid_n = 1'b1;
          state_n = EMIT_A;
        end
      end

      EMIT_A: begin
        if (out_ready) begin
          field_n = b_ext;
          sel_n   = SEL_B;
          last_n  = 1'b1;
          valid_n = 1'b1;
          state_n = EMIT_B;
        end
      end

      EMIT_B: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            hold_n  = in_cat[WIDTH_B-1:0];
            field_n = a_ext;
            sel_n   = SEL_A;
            last_n  = 1'b0;
            valid_n = 1'b1;
            state_n = EMIT_A;
          end else begin
            sel_n   = SEL_A;
            last_n  = 1'b0;
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end

      default: begin
        sel_n   = SEL_A;
        last_n  = 1'b0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, hold register and registered outputs; reset discards any word
  // in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold register is reset too; it is a single small register,
      // not a memory array, so clearing it is cheap and keeps it deterministic.
      state     <= IDLE;
      hold      <= '0;
      out_field <= '0;
      out_sel   <= SEL_A;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state     <= state_n;
      hold      <= hold_n;
      out_field <= field_n;
      out_sel   <= sel_n;
      out_last  <= last_n;
      out_valid <= valid_n;
    end
  end

endmodule

// File: doc/widths_unpack.md
# widths_unpack

Serializing unpacker: accepts one concatenated word `{a, b}` per handshake and emits its two fields in order, A then B, on a single field-wide output stream. It is the receive-side counterpart of the widths concatenation path. It sits after a link or FIFO that carries packed words and feeds consumers that handle one field at a time. It has one state machine, one holding register and registered outputs, with full throughput of one word every two cycles.

## Interface
- `WIDTH_A`, default 5: width of field A, the upper bits of the packed word; must be ≥1.
- `WIDTH_B`, default 3: width of field B, the lower bits of the packed word; must be ≥1.
- `FW`, derived and not overridable: max(`WIDTH_A`, `WIDTH_B`), the output field width.
- `clk` input 1: the single clock; all logic is rising-edge.
- `rst` input 1: asynchronous reset, active-high.
- `in_cat` input `WIDTH_A+WIDTH_B`: packed word `{a, b}`; `a = in_cat[WA+WB-1:WB]`, `b = in_cat[WB-1:0]`.
- `in_valid` input 1: `in_cat` is valid.
- `in_ready` output 1: the block accepts `in_cat` this cycle.
- `out_field` output `FW`: current field, extended to `FW`.
- `out_sel` output 1: 0 means field A, 1 means field B.
- `out_last` output 1: high with field B (the last field of the word).
- `out_valid` output 1: the output beat is valid.
- `out_ready` input 1: the downstream consumer accepts the beat.

## Operation
- States are IDLE, EMIT_A and EMIT_B, encoded 2 bits.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_cat` into the hold register, load the A field onto the outputs, go to EMIT_A.
- EMIT_A:
  - `out_valid`=1, `out_sel`=0, `out_last`=0.
  - On `out_ready`: load the B field from the hold register, go to EMIT_B.
  - Otherwise hold all outputs stable.
- EMIT_B:
  - `out_valid`=1, `out_sel`=1, `out_last`=1.
  - `in_ready` = `out_ready` (combinational pass-through; the only combinational path).
  - If `out_ready` && `in_valid`: latch the new word, load its A field, go to EMIT_A. This is back-to-back with no bubble.
  - If `out_ready` && !`in_valid`: go to IDLE, `out_valid`=0.
  - If !`out_ready`: hold.
- `in_ready`=0 in EMIT_A.
- `in_ready`=0 in EMIT_B when `out_ready`=0.
- Field extension: the narrower field is zero-extended to `FW` (see Configuration). With `WIDTH_A`==`WIDTH_B`, no extension happens.
- The upstream side may drop `in_valid` at any time. A word is consumed only on `in_valid`&&`in_ready`.
- The downstream side must hold `out_ready` semantics per beat. Output data is stable while `out_valid`&&!`out_ready`.
- A beat is never dropped and never duplicated. A and B are always emitted as an adjacent pair in that order.

## Timing
- Reset values: state=IDLE, hold=0, `out_field`=0, `out_sel`=0, `out_last`=0, `out_valid`=0, `in_ready`=1.
- Reset is effective immediately and asynchronously, including mid-word. A partially emitted word is discarded and is not resumed after reset.
- Latency:
  - A word accepted at edge t presents A at t+1 (registered).
  - B appears at the edge after A handshakes.
- Throughput: 1 word per 2 cycles with `out_ready` held high and `in_valid` held high.
- Deassertion of `rst` is synchronized externally; the block requires no recovery cycles.

## Configuration
- Macro: `WIDTHS_UNPACK_SIGN_EXT_EN`.
- Defined: the narrower field is sign-extended (its MSB is replicated) to `FW`.
- Undefined (default): the narrower field is zero-extended.
- The macro affects only the extension function. Handshake and timing are identical in both builds.

## Structure
- Shared package `widths_pkg`:
  - State enum `unpack_state_t` (IDLE, EMIT_A, EMIT_B).
  - Constant function `wmax(a,b)` used for `FW`.
  - Localparams for the field select encodings (`SEL_A`=0, `SEL_B`=1).
- One sub-module `widths_field_ext #(IN_W, OUT_W)`: purely combinational zero/sign extender, used once per field. The `WIDTHS_UNPACK_SIGN_EXT_EN` macro is honoured inside it.

## Test plan
All scenarios use `WIDTH_A`=5, `WIDTH_B`=3, so `FW`=5.
- Reset check: assert `rst` → `out_valid`=0, `out_field`=0, `in_ready`=1, state IDLE.
- Single word: `in_cat`=8'hB5 with `out_ready`=1 → cycle+1: `out_field`=5'h16, `out_sel`=0; cycle+2: `out_field`=5'h05, `out_sel`=1, `out_last`=1; cycle+3: `out_valid`=0.
- Sign-extension build: same stimulus with `WIDTHS_UNPACK_SIGN_EXT_EN` defined → B beat `out_field`=5'h1D, A beat unchanged at 5'h16.
- Back-to-back: words 8'hB5, 8'h0A, 8'hFF streamed with `in_valid` and `out_ready` high → beats 16,05,01,02,1F,07 on consecutive cycles; `in_ready` high only on the B-beat cycles.
- Backpressure: `out_ready`=0 for 4 cycles during the A beat → outputs stable and `in_ready`=0 throughout; release → B follows next cycle, with no loss or duplication.
- Reset mid-word: assert `rst` while in EMIT_B with `out_ready`=0 → outputs return to reset values immediately; the next word after release emits its A field first.
